// File: rtl/insn_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package insn_loader_pkg;

    localparam int BYTES_PER_WORD     = 4;
    localparam int DEFAULT_ADDR_WIDTH = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RUN   = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

endpackage

// File: rtl/insn_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words, one lane per accepted byte.
module byte_packer
    import insn_loader_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          clear_i,
    input  logic                          push_i,
    input  logic [7:0]                    byte_i,
    output logic [8*BYTES_PER_WORD-1:0]   word_o,
    output logic                          word_full_o
);

    logic [1:0]  r_lane;
    logic [23:0] r_low;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_lane <= '0;
        end else if (clear_i) begin
            r_lane <= '0;
        end else if (push_i) begin
            r_lane <= r_lane + 2'd1;
        end
    end

    // Only the lower three lanes are stored; the top lane is forwarded directly
    // so the completed word is available on the cycle of the fourth handshake.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            case (r_lane)
                2'd0:    r_low[7:0]   <= byte_i;
                2'd1:    r_low[15:8]  <= byte_i;
                2'd2:    r_low[23:16] <= byte_i;
                default: ;
            endcase
        end
    end

    assign word_o      = {byte_i, r_low};
    assign word_full_o = push_i && (r_lane == 2'd3);

endmodule

// File: rtl/insn_loader_ctrl.sv
// Boot/reload controller: streams bytes into instruction memory and gates CPU reset.
module insn_loader_ctrl
    import insn_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  load_start_i,
    input  logic [ADDR_WIDTH:0]   load_len_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    output logic                  byte_ready_o,
    input  logic                  ebreak_i,
    output logic                  insn_mem_wen_o,
    output logic [ADDR_WIDTH-1:0] insn_mem_waddr_o,
    output logic [31:0]           insn_o,
    output logic                  cpu_rstn_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_wcnt;
    logic [ADDR_WIDTH:0]   w_wcnt_nxt;
    logic [ADDR_WIDTH:0]   w_eff_len;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [31:0]           r_insn;
    logic [31:0]           w_word;
    logic                  w_start_ok;
    logic                  w_push;
    logic                  w_word_full;
    logic                  r_byte_ready;
    logic                  r_wen;
    logic                  r_cpu_rstn;
    logic                  r_busy;
    logic                  r_done;

    // Lengths above the memory capacity are clamped to a full image.
    assign w_eff_len  = load_len_i[ADDR_WIDTH] ? MAX_LEN : load_len_i;
    assign w_start_ok = load_start_i && (w_eff_len != '0) &&
                        ((r_state == ST_IDLE) || (r_state == ST_HALT));
    assign w_push     = byte_valid_i && (r_state == ST_RECV);
    assign w_wcnt_nxt = r_wcnt + 1'b1;

    byte_packer u_packer (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .clear_i     (w_start_ok),
        .push_i      (w_push),
        .byte_i      (byte_i),
        .word_o      (w_word),
        .word_full_o (w_word_full)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_HALT: if (w_start_ok)  w_state_nxt = ST_RECV;
            ST_RECV:          if (w_word_full) w_state_nxt = ST_WRITE;
            ST_WRITE:         w_state_nxt = (w_wcnt_nxt == r_len) ? ST_RUN : ST_RECV;
            ST_RUN:           if (ebreak_i)    w_state_nxt = ST_HALT;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_wcnt       <= '0;
            r_addr       <= '0;
            r_waddr      <= '0;
            r_insn       <= '0;
            r_byte_ready <= 1'b0;
            r_wen        <= 1'b0;
            r_cpu_rstn   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_ready <= (w_state_nxt == ST_RECV);
            r_wen        <= (w_state_nxt == ST_WRITE);
            r_busy       <= (w_state_nxt == ST_RECV) || (w_state_nxt == ST_WRITE);
            r_cpu_rstn   <= (w_state_nxt == ST_RUN);
            r_done       <= (w_state_nxt == ST_HALT);
            if (w_start_ok) begin
                r_len  <= w_eff_len;
                r_wcnt <= '0;
                r_addr <= '0;
            end
            if (w_word_full) begin
                r_insn  <= w_word;
                r_waddr <= r_addr;
            end
            if (r_state == ST_WRITE) begin
                r_addr <= r_addr + 1'b1;
                r_wcnt <= w_wcnt_nxt;
            end
        end
    end

    assign byte_ready_o     = r_byte_ready;
    assign insn_mem_wen_o   = r_wen;
    assign insn_mem_waddr_o = r_waddr;
    assign insn_o           = r_insn;
    assign cpu_rstn_o       = r_cpu_rstn;
    assign busy_o           = r_busy;
    assign done_o           = r_done;

endmodule
